bus_peripheral_gen: RTL and testbench

BUS_PERIPHERAL_GEN -- requirements
Module: bus_peripheral_gen

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_peripheral_gen_if.sv | 15 +
 rtl/iom_mem_array.sv | 29 ++
 rtl/bus_peripheral_gen.sv | 140 ++++++++++++++
 tb/tb_bus_peripheral_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the 8-bit peripheral bus slaves.
package bus_pkg;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    WAIT  = 3'd2,
    DRIVE = 3'd3,
    HOLD  = 3'd4
  } bus_state_t;

  // True when addr falls in the 2**abits-byte window that starts at base.
  function automatic logic region_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input int                abits);
    return (addr >> abits) == (base >> abits);
  endfunction

endpackage

// File: rtl/bus_peripheral_gen_if.sv
// Control/address side of the multiplexed peripheral bus; the data bus stays a plain inout.
interface bus_peripheral_gen_if;
  import bus_pkg::*;

  logic              ALE;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] Address;
  logic              READY;

  modport master (output ALE, IOM, RD, WR, Address, input READY);
  modport slave  (input ALE, IOM, RD, WR, Address, output READY);

endinterface

// File: rtl/iom_mem_array.sv
// Byte storage with one synchronous write port and one registered read port; never cleared.
module iom_mem_array
  import bus_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_BITS];

  // Write port.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge CLK) begin
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/bus_peripheral_gen.sv
// Bus slave serving one aligned memory or I/O window, with optional wait states and a tri-state data port.
module bus_peripheral_gen
  import bus_pkg::*;
#(
  parameter bit                IS_IO       = 1'b0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h00000,
  parameter int                ADDR_BITS   = 10,
  parameter int                WAIT_STATES = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  bus_peripheral_gen_if.slave bus,
  inout  wire  [DATA_W-1:0]   Data
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK_C = (20'd1 << ADDR_BITS) - 20'd1;
  localparam logic [2:0]        WAIT_LOAD_C  = 3'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
    $error("bus_peripheral_gen: WAIT_STATES out of range 0..MAX_WAIT");
  end
  if (ADDR_BITS < 4 || ADDR_BITS > 16) begin : g_bad_abits
    $error("bus_peripheral_gen: ADDR_BITS out of range 4..16");
  end
  if ((BASE_ADDR & ALIGN_MASK_C) != 20'd0) begin : g_bad_base
    $error("bus_peripheral_gen: BASE_ADDR not aligned to 2**ADDR_BITS");
  end

  bus_state_t             state_r, state_nxt_s;
  logic [ADDR_BITS-1:0]   offset_r, offset_nxt_s;
  logic [2:0]             wait_cnt_r, wait_cnt_nxt_s;
  logic                   is_read_r, is_read_nxt_s;
  logic                   ready_r;
  logic                   drive_r;
  logic                   wr_en_s;
  logic                   mem_we_s;
  logic                   addr_hit_s;
  logic                   strobe_off_s;
  logic [DATA_W-1:0]      rd_data_s;

  assign addr_hit_s   = (bus.IOM == IS_IO) && region_hit(bus.Address, BASE_ADDR, ADDR_BITS);
  assign strobe_off_s = is_read_r ? bus.RD : bus.WR;

  // Next-state decode of the bus cycle and write-strobe generation.
  always_comb begin
    state_nxt_s    = state_r;
    offset_nxt_s   = offset_r;
    wait_cnt_nxt_s = wait_cnt_r;
    is_read_nxt_s  = is_read_r;
    wr_en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.ALE) begin
          offset_nxt_s = bus.Address[ADDR_BITS-1:0];
          state_nxt_s  = addr_hit_s ? SEL : IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEL: begin
        if (!bus.RD && !bus.WR) begin
          state_nxt_s = IDLE;
        end else if (!bus.RD || !bus.WR) begin
          is_read_nxt_s = !bus.RD;
          if (WAIT_STATES > 0) begin
            state_nxt_s    = WAIT;
            wait_cnt_nxt_s = WAIT_LOAD_C;
          end else if (!bus.RD) begin
            state_nxt_s = DRIVE;
          end else begin
            state_nxt_s = HOLD;
            wr_en_s     = 1'b1;
          end
        end else if (bus.ALE) begin
          // A fresh address phase without a strobe re-runs the decode.
          offset_nxt_s = bus.Address[ADDR_BITS-1:0];
          state_nxt_s  = addr_hit_s ? SEL : IDLE;
        end else begin
          state_nxt_s = SEL;
        end
      end
      WAIT: begin
        if (strobe_off_s) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = 3'd0;
        end else if (wait_cnt_r <= 3'd1) begin
          wait_cnt_nxt_s = 3'd0;
          if (is_read_r) begin
            state_nxt_s = DRIVE;
          end else begin
            state_nxt_s = HOLD;
            wr_en_s     = 1'b1;
          end
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 3'd1;
        end
      end
      DRIVE:   state_nxt_s = bus.RD ? IDLE : DRIVE;
      HOLD:    state_nxt_s = bus.WR ? IDLE : HOLD;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latched offset and registered bus outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      offset_r   <= '0;
      wait_cnt_r <= 3'd0;
      is_read_r  <= 1'b0;
      ready_r    <= 1'b1;
      drive_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      offset_r   <= offset_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      is_read_r  <= is_read_nxt_s;
      ready_r    <= (state_nxt_s != WAIT);
      drive_r    <= (state_nxt_s == DRIVE);
    end
  end

  // A reset edge must never coincide with a commit.
  assign mem_we_s = wr_en_s && !RESET;

  iom_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (mem_we_s),
    .wr_addr (offset_r),
    .wr_data (Data),
    .rd_addr (offset_r),
    .rd_data (rd_data_s)
  );

  assign bus.READY = ready_r;
  assign Data      = drive_r ? rd_data_s : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_peripheral_gen.sv
// Four peripherals on one bus: directed corner cases, then random traffic against a scoreboard.
module tb_bus_peripheral_gen;
  import bus_pkg::*;

  localparam bit          IO_P   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [19:0] BASE_P [4] = '{20'h04000, 20'h0C000, 20'h00400, 20'h00800};
  localparam int          AB_P   [4] = '{10, 10, 10, 8};
  localparam int          WS_P   [4] = '{0, 3, 0, 2};

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         ws;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ale, iom, rd, wr, tb_oe, close_s, mon_en;
  logic [19:0] addr;
  logic [7:0]  tb_d;
  logic [3:0]  ready_v, oe_v;
  logic [7:0]  dv [4];

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];
  logic [7:0] mdl [4][1024];
  bit         vld [4][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bus_peripheral_gen_if bif ();
    wire [7:0] d_net;
    assign bif.ALE     = ale;
    assign bif.IOM     = iom;
    assign bif.RD      = rd;
    assign bif.WR      = wr;
    assign bif.Address = addr;
    assign d_net       = tb_oe ? tb_d : 8'hzz;
    assign ready_v[g]  = bif.READY;
    assign oe_v[g]     = u_dut.drive_r;
    assign dv[g]       = d_net;
    bus_peripheral_gen #(
      .IS_IO(IO_P[g]), .BASE_ADDR(BASE_P[g]), .ADDR_BITS(AB_P[g]), .WAIT_STATES(WS_P[g])
    ) u_dut (
      .CLK(clk), .RESET(rst), .bus(bif.slave), .Data(d_net)
    );
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int hit_inst(input bit iom_v, input logic [19:0] a);
    for (int i = 0; i < 4; i++) begin
      if (iom_v == IO_P[i] && (a >> AB_P[i]) == (BASE_P[i] >> AB_P[i])) return i;
    end
    return -1;
  endfunction

  function automatic int offset_of(input int inst, input logic [19:0] a);
    return int'(a & ((20'd1 << AB_P[inst]) - 20'd1));
  endfunction

  task automatic bus_cycle(input bit iom_v, input logic [19:0] a1, input bit two_ale,
                           input logic [19:0] a2, input bit do_rd, input bit do_wr,
                           input logic [7:0] wd, input int hold);
    @(posedge clk); #1;
    ale = 1'b1; iom = iom_v; addr = a1;
    if (two_ale) begin
      @(posedge clk); #1;
      addr = a2;
    end
    @(posedge clk); #1;
    ale = 1'b0; rd = !do_rd; wr = !do_wr; tb_d = wd; tb_oe = do_wr;
    repeat (hold) @(posedge clk);
    #1;
    rd = 1'b1; wr = 1'b1; tb_oe = 1'b0;
    @(posedge clk); #1; close_s = 1'b1;
    @(posedge clk); #1; close_s = 1'b0;
  endtask

  task automatic do_read(input bit iom_v, input logic [19:0] a, input int einst, input logic [7:0] ed);
    exp_q.push_back('{einst, ed, (einst >= 0) ? WS_P[einst] : 0});
    bus_cycle(iom_v, a, 1'b0, 20'h00000, 1'b1, 1'b0, 8'h00, 6);
  endtask

  task automatic do_write(input bit iom_v, input logic [19:0] a, input logic [7:0] d, input int einst);
    exp_q.push_back('{-1, 8'h00, (einst >= 0) ? WS_P[einst] : 0});
    bus_cycle(iom_v, a, 1'b0, 20'h00000, 1'b0, 1'b1, d, 6);
    if (einst >= 0) begin
      mdl[einst][offset_of(einst, a)] = d;
      vld[einst][offset_of(einst, a)] = 1'b1;
    end
  endtask

  // Monitor: accumulates per-access observations and pops the scoreboard at each access close.
  initial begin : monitor
    int n_oe, drv_idx, rlow, lat;
    bit seen;
    logic [7:0] dval;
    exp_t e;
    n_oe = 0; drv_idx = -1; rlow = 0; lat = 0; seen = 1'b0; dval = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_oe = 0;
        for (int i = 0; i < 4; i++) begin
          if (oe_v[i]) begin
            n_oe++;
            if (!seen) begin
              seen = 1'b1; drv_idx = i; dval = dv[i];
            end
          end
        end
        cmp("one_driver", ((n_oe > 1) || (n_oe > 0 && tb_oe)) ? 1 : 0, 0);
        if (!(&ready_v)) rlow++;
        if (!seen && rd == 1'b0) lat++;
        if (close_s) begin
          cmp("released", n_oe, 0);
          if (exp_q.size() == 0) begin
            cmp("queue_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            cmp("drv_inst", drv_idx, e.inst);
            if (e.inst >= 0) begin
              cmp("rd_data", int'(dval), int'(e.data));
              cmp("rd_latency", lat, e.ws + 1);
            end
            cmp("ready_low", rlow, e.ws);
          end
          seen = 1'b0; drv_idx = -1; rlow = 0; lat = 0; dval = 8'h00;
        end
      end
    end
  end

  initial begin : stimulus
    int k, off, r;
    logic [19:0] a;
    logic [7:0]  d;
    rst = 1'b1; ale = 1'b0; iom = 1'b0; rd = 1'b1; wr = 1'b1;
    tb_oe = 1'b0; tb_d = 8'h00; addr = 20'h00000; close_s = 1'b0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cmp("rst_ready", int'(ready_v[i]), 1);
      cmp("rst_oe", int'(oe_v[i]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; mon_en = 1'b1;

    do_write(1'b0, 20'h04010, 8'hA5, 0);
    do_read (1'b0, 20'h04010, 0, 8'hA5);
    do_write(1'b0, 20'h04040, 8'hC3, 0);
    do_write(1'b0, 20'h0C010, 8'h5A, 1);
    do_read (1'b0, 20'h0C010, 1, 8'h5A);
    do_read (1'b1, 20'h04010, -1, 8'h00);
    do_read (1'b0, 20'h08010, -1, 8'h00);
    do_write(1'b1, 20'h00410, 8'h11, 2);
    do_read (1'b1, 20'h00410, 2, 8'h11);
    do_write(1'b1, 20'h008FF, 8'hEE, 3);
    do_read (1'b1, 20'h008FF, 3, 8'hEE);
    do_write(1'b0, 20'h0C3FF, 8'h81, 1);
    do_read (1'b0, 20'h0C3FF, 1, 8'h81);

    // RD and WR together: no write, no drive.
    exp_q.push_back('{-1, 8'h00, 0});
    bus_cycle(1'b0, 20'h04010, 1'b0, 20'h00000, 1'b1, 1'b1, 8'h77, 3);
    do_read(1'b0, 20'h04010, 0, 8'hA5);

    // Strobes dropped during WAIT abort the access.
    exp_q.push_back('{-1, 8'h00, 1});
    bus_cycle(1'b0, 20'h0C010, 1'b0, 20'h00000, 1'b1, 1'b0, 8'h00, 1);
    exp_q.push_back('{-1, 8'h00, 1});
    bus_cycle(1'b0, 20'h0C010, 1'b0, 20'h00000, 1'b0, 1'b1, 8'h99, 1);
    do_read(1'b0, 20'h0C010, 1, 8'h5A);

    // Second ALE in SEL re-decodes: to another offset, then to an unmapped address.
    exp_q.push_back('{0, 8'hC3, 0});
    bus_cycle(1'b0, 20'h04030, 1'b1, 20'h04040, 1'b1, 1'b0, 8'h00, 6);
    exp_q.push_back('{-1, 8'h00, 0});
    bus_cycle(1'b0, 20'h04030, 1'b1, 20'h08000, 1'b1, 1'b0, 8'h00, 6);

    // Reset lands on the edge that would have committed 8'h3C.
    do_write(1'b0, 20'h0C020, 8'hA5, 1);
    exp_q.push_back('{-1, 8'h00, 3});
    @(posedge clk); #1;
    ale = 1'b1; iom = 1'b0; addr = 20'h0C020;
    @(posedge clk); #1;
    ale = 1'b0; wr = 1'b0; tb_d = 8'h3C; tb_oe = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr = 1'b1; tb_oe = 1'b0;
    cmp("rst_mid_ready", int'(ready_v[1]), 1);
    cmp("rst_mid_oe", int'(oe_v[1]), 0);
    @(posedge clk); #1; close_s = 1'b1;
    @(posedge clk); #1; close_s = 1'b0;
    do_read(1'b0, 20'h0C020, 1, 8'hA5);

    for (int n = 0; n < 1000; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a = 20'h70000 | 20'($urandom_range(0, 16'hFFFF));
        do_read(1'($urandom_range(0, 1)), a, -1, 8'h00);
      end else begin
        k   = $urandom_range(0, 3);
        off = $urandom_range(0, (1 << AB_P[k]) - 1);
        a   = BASE_P[k] | 20'(off);
        if (!vld[k][off] || r < 5) begin
          d = 8'($urandom_range(0, 255));
          do_write(IO_P[k], a, d, hit_inst(IO_P[k], a));
        end else begin
          do_read(IO_P[k], a, hit_inst(IO_P[k], a), mdl[k][off]);
        end
      end
    end

    repeat (2) @(posedge clk);
    cmp("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
